// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants and state encoding for the CORDIC result unpacker
package cordic_pkg;

  localparam int RES_BYTES       = 6;
  localparam int MAG_BYTES       = 2;
  localparam int PHASE_BYTES     = 4;
  localparam int GAP_TIMEOUT_DEF = 255;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

endpackage

// File: rtl/cordic_gap_timer.sv
// rtl/cordic_gap_timer.sv - inter-byte idle counter, pulses expired on the edge it reaches GAP_TIMEOUT
module cordic_gap_timer
  import cordic_pkg::*;
#(
  parameter int GAP_TIMEOUT = GAP_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(GAP_TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;

  // A clear on the firing edge suppresses the pulse: an arriving byte beats the timeout.
  always_comb begin
    expired = enable && !clear && (cnt_q == LAST);
    cnt_d   = cnt_q;
    if (clear || expired || !enable) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cordic_result_unpacker.sv
// rtl/cordic_result_unpacker.sv - assembles 6-byte little-endian CORDIC results into mag/phase frames
module cordic_result_unpacker
  import cordic_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int PHASE_W     = 32,
  parameter int GAP_TIMEOUT = GAP_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         byte_data,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic [WIDTH-1:0]   mag,
  output logic [PHASE_W-1:0] phase,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               frame_err,
  output logic [7:0]         frame_cnt
);

  localparam int          BUF_W     = 8 * (RES_BYTES - 1);
  localparam logic [2:0]  LAST_BYTE = 3'(RES_BYTES - 1);

  state_e               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [BUF_W-1:0]     buf_q, buf_d;
  logic [WIDTH-1:0]     mag_q, mag_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic                 frame_err_q, frame_err_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;
  logic                 byte_fire, res_fire, gap_expired;

  assign byte_ready = (state_q == COLLECT);
  assign res_valid  = (state_q == HOLD);
  assign byte_fire  = byte_valid && byte_ready;
  assign res_fire   = res_valid && res_ready;
  assign mag        = mag_q;
  assign phase      = phase_q;
  assign frame_err  = frame_err_q;
  assign frame_cnt  = frame_cnt_q;

  cordic_gap_timer #(
    .GAP_TIMEOUT(GAP_TIMEOUT)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (byte_ready && (idx_q != 3'd0)),
    .clear  (byte_fire),
    .expired(gap_expired)
  );

  // Bytes 0..4 shift into a staging buffer so mag/phase only change when a frame completes.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    mag_d       = mag_q;
    phase_d     = phase_q;
    frame_cnt_d = frame_cnt_q;
    frame_err_d = gap_expired;
    case (state_q)
      COLLECT: begin
        if (byte_fire) begin
          if (idx_q == LAST_BYTE) begin
            mag_d   = buf_q[WIDTH-1:0];
            phase_d = {byte_data, buf_q[WIDTH +: PHASE_W-8]};
            idx_d   = 3'd0;
            state_d = HOLD;
          end else begin
            buf_d = {byte_data, buf_q[BUF_W-1:8]};
            idx_d = idx_q + 3'd1;
          end
        end else if (gap_expired) begin
          idx_d = 3'd0;
        end
      end
      HOLD: begin
        if (res_fire) begin
          state_d     = COLLECT;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      idx_q       <= 3'd0;
      buf_q       <= '0;
      mag_q       <= '0;
      phase_q     <= '0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      mag_q       <= mag_d;
      phase_q     <= phase_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_cordic_result_unpacker.sv
// tb/tb_cordic_result_unpacker.sv - scoreboard bench for cordic_result_unpacker
module tb_cordic_result_unpacker;

  logic        clk;
  logic        rst;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] mag;
  logic [31:0] phase;
  logic        res_valid;
  logic        res_ready;
  logic        frame_err;
  logic [7:0]  frame_cnt;

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;
  logic [7:0]  exp_cnt = 8'd0;
  logic [47:0] exp_q[$];

  cordic_result_unpacker #(
    .WIDTH(16),
    .PHASE_W(32),
    .GAP_TIMEOUT(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .mag       (mag),
    .phase     (phase),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame handoffs are scored at the falling edge ahead of the transfer edge.
  initial begin
    logic [47:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        exp_cnt = 8'd0;
      end else begin
        if (frame_err) err_pulses++;
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("mag", 64'(mag), 64'(e[15:0]));
            check("phase", 64'(phase), 64'(e[47:16]));
            check("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
            exp_cnt = exp_cnt + 8'd1;
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_data  = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) check("byte_accept_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] f);
    exp_q.push_back(f);
    for (int i = 0; i < 6; i++) send_byte(f[8*i +: 8]);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int e0;
    logic [47:0] f;
    rst        = 1'b1;
    byte_data  = 8'h00;
    byte_valid = 1'b0;
    res_ready  = 1'b1;
    do_reset();

    check("rst_byte_ready", 64'(byte_ready), 64'd1);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_mag", 64'(mag), 64'd0);
    check("rst_phase", 64'(phase), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);

    // Back-to-back frame, consumer always ready: res_valid lasts one cycle.
    send_frame(48'h12345678_384E);
    check("b2b_res_valid", 64'(res_valid), 64'd1);
    check("b2b_byte_ready_hold", 64'(byte_ready), 64'd0);
    @(posedge clk);
    #1;
    check("b2b_res_valid_drop", 64'(res_valid), 64'd0);
    check("b2b_byte_ready_back", 64'(byte_ready), 64'd1);
    check("b2b_frame_cnt", 64'(frame_cnt), 64'd1);

    // Back-pressure: frame held stable, byte offered in HOLD is ignored.
    res_ready = 1'b0;
    send_frame(48'hCAFEBABE_1357);
    byte_data  = 8'hAA;
    byte_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_res_valid", 64'(res_valid), 64'd1);
      check("hold_byte_ready", 64'(byte_ready), 64'd0);
      check("hold_mag", 64'(mag), 64'h1357);
      check("hold_phase", 64'(phase), 64'hCAFEBABE);
    end
    byte_valid = 1'b0;
    res_ready  = 1'b1;
    @(posedge clk);
    #1;
    check("hold_release", 64'(res_valid), 64'd0);
    check("hold_frame_cnt", 64'(frame_cnt), 64'd2);

    // Timeout after 3 bytes and 8 idle cycles.
    e0 = err_pulses;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    repeat (10) @(posedge clk);
    #1;
    check("timeout_err_once", 64'(err_pulses), 64'(e0 + 1));
    check("timeout_mag_kept", 64'(mag), 64'h1357);
    check("timeout_phase_kept", 64'(phase), 64'hCAFEBABE);
    send_frame(48'h80000000_7FFF);
    drain();

    // Byte arriving on the 8th idle cycle wins over the timeout.
    e0 = err_pulses;
    f  = 48'hA1B2C3D4_E5F6;
    exp_q.push_back(f);
    for (int i = 0; i < 3; i++) send_byte(f[8*i +: 8]);
    repeat (7) @(posedge clk);
    #1;
    for (int i = 3; i < 6; i++) send_byte(f[8*i +: 8]);
    drain();
    repeat (12) @(posedge clk);
    #1;
    check("edge_no_err", 64'(err_pulses), 64'(e0));

    // Idle with no partial frame never times out.
    e0 = err_pulses;
    repeat (300) @(posedge clk);
    #1;
    check("idle_no_err", 64'(err_pulses), 64'(e0));

    // Reset after byte index 4 discards the partial frame silently.
    e0 = err_pulses;
    for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i));
    do_reset();
    check("midrst_mag", 64'(mag), 64'd0);
    check("midrst_phase", 64'(phase), 64'd0);
    check("midrst_res_valid", 64'(res_valid), 64'd0);
    check("midrst_byte_ready", 64'(byte_ready), 64'd1);
    check("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
    send_frame(48'h0BADF00D_2468);
    drain();
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_err", 64'(err_pulses), 64'(e0));

    // Reset while a frame is held.
    res_ready = 1'b0;
    send_frame(48'h55AA55AA_9999);
    repeat (2) @(posedge clk);
    do_reset();
    res_ready = 1'b1;
    check("holdrst_res_valid", 64'(res_valid), 64'd0);
    check("holdrst_mag", 64'(mag), 64'd0);
    check("holdrst_phase", 64'(phase), 64'd0);
    check("holdrst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("holdrst_no_err", 64'(err_pulses), 64'(e0));

    // 256 random frames wrap frame_cnt back to 0.
    for (int k = 0; k < 256; k++) begin
      f = {32'($urandom), 16'($urandom_range(0, 65535))};
      send_frame(f);
    end
    drain();
    check("wrap_frame_cnt", 64'(frame_cnt), 64'd0);
    check("wrap_no_err", 64'(err_pulses), 64'(e0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
